// File: rtl/segment_scanner.sv
// Accumulates multiplexed CPU LCD drive per frame and commits it one line per cycle after vblank rises.
// Line l updates at the edge ending cycle E+1+l (E = first vblank-high cycle); no backpressure, CPU writes always accepted.
module segment_scanner #(
   parameter int MAX_X_SEGMENT = 9,
   parameter int MAX_Y_SEGMENT = 16,
   parameter int MAX_Z_SEGMENT = 4,
   parameter int FADE_FRAMES   = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     vblank,
   input  logic                     cpu_seg_wr,
   input  logic [3:0]               cpu_line,
   input  logic [MAX_Y_SEGMENT-1:0] cpu_column_data,
   input  logic [MAX_Z_SEGMENT-1:0] cpu_row_sel,
   input  logic                     lcd_blank,
   output logic [MAX_Z_SEGMENT-1:0] segments [MAX_X_SEGMENT][MAX_Y_SEGMENT],
   output logic                     commit_busy
);
   localparam int FW = $clog2(FADE_FRAMES + 1);
   localparam int IW = $clog2(MAX_X_SEGMENT);
   localparam logic [FW-1:0] FADE_INIT = FW'(FADE_FRAMES);
   localparam logic [FW-1:0] FADE_ONE  = FW'(1);
   localparam logic [IW-1:0] LAST_LINE = IW'(MAX_X_SEGMENT - 1);

   typedef enum logic {ACCUM, COMMIT} state_t;

   state_t                   state, state_nxt;
   logic [IW-1:0]            line_idx;
   logic                     vblank_prev;
   logic                     rise;
   logic                     line_ok;
   logic [MAX_Z_SEGMENT-1:0] acc     [MAX_X_SEGMENT][MAX_Y_SEGMENT];
   logic [MAX_Z_SEGMENT-1:0] acc_nxt [MAX_X_SEGMENT][MAX_Y_SEGMENT];
   logic [FW-1:0]            fade    [MAX_X_SEGMENT][MAX_Y_SEGMENT][MAX_Z_SEGMENT];
   logic [FW-1:0]            fade_line_nxt [MAX_Y_SEGMENT][MAX_Z_SEGMENT];
   logic [MAX_Z_SEGMENT-1:0] seg_line_nxt  [MAX_Y_SEGMENT];

   assign rise        = vblank & ~vblank_prev;
   assign line_ok     = cpu_seg_wr && (int'(cpu_line) < MAX_X_SEGMENT);
   assign commit_busy = (state == COMMIT);

   // Clear of the line being committed happens before the OR, so a same-cycle write survives into next frame.
   always_comb begin
      acc_nxt = acc;
      if (state == COMMIT) begin
         for (int y = 0; y < MAX_Y_SEGMENT; y++) acc_nxt[line_idx][y] = '0;
      end
      if (line_ok) begin
         for (int y = 0; y < MAX_Y_SEGMENT; y++)
            acc_nxt[cpu_line][y] = acc_nxt[cpu_line][y] |
                                   ({MAX_Z_SEGMENT{cpu_column_data[y]}} & cpu_row_sel);
      end
   end

   always_comb begin
      fade_line_nxt = '{default: '0};
      seg_line_nxt  = '{default: '0};
      for (int y = 0; y < MAX_Y_SEGMENT; y++) begin
         for (int z = 0; z < MAX_Z_SEGMENT; z++) begin
            if (acc[line_idx][y][z])
               fade_line_nxt[y][z] = FADE_INIT;
            else if (fade[line_idx][y][z] != '0)
               fade_line_nxt[y][z] = fade[line_idx][y][z] - FADE_ONE;
            else
               fade_line_nxt[y][z] = '0;
            seg_line_nxt[y][z] = (fade_line_nxt[y][z] != '0) & ~lcd_blank;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM:   if (rise) state_nxt = COMMIT;
         COMMIT:  if (line_idx == LAST_LINE) state_nxt = ACCUM;
         default: state_nxt = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ACCUM;
      else          state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vblank_prev <= 1'b0;
         line_idx    <= '0;
         acc         <= '{default: '0};
         fade        <= '{default: '0};
         segments    <= '{default: '0};
      end else begin
         vblank_prev <= vblank;
         acc         <= acc_nxt;
         if (state == COMMIT) begin
            for (int y = 0; y < MAX_Y_SEGMENT; y++) begin
               segments[line_idx][y] <= seg_line_nxt[y];
               for (int z = 0; z < MAX_Z_SEGMENT; z++)
                  fade[line_idx][y][z] <= fade_line_nxt[y][z];
            end
            line_idx <= (line_idx == LAST_LINE) ? '0 : line_idx + 1'b1;
         end else if (rise) begin
            line_idx <= '0;
         end
      end
   end
endmodule

// File: doc/segment_scanner.md
Name: segment_scanner

Overview:
- Converts the CPU's multiplexed LCD drive into a stable per-frame segment state array.
- The CPU drive is a line select, a column bitmask and common/row strobes.
- The output array feeds the segment renderer, indexed [line][column][row].
- Writes are accumulated during the frame and committed one line per cycle after vblank rises, which avoids tearing.
- A per-segment fade counter emulates LCD persistence, so a segment that is briefly not driven does not flicker.

Parameters:
- MAX_X_SEGMENT, 9, number of segment lines (x).
- MAX_Y_SEGMENT, 16, columns per line (y).
- MAX_Z_SEGMENT, 4, common/row strobes (z).
- FADE_FRAMES, 2, number of frames a segment stays lit after its last drive; legal range 1..15; 1 means no persistence.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- vblank  in  1  video vertical blank level; only its rising edge is used.
- cpu_seg_wr  in  1  single-cycle strobe; when high, the current drive is accumulated.
- cpu_line  in  4  segment line select x.
- cpu_column_data  in  MAX_Y_SEGMENT  lit-column bitmask for the selected line.
- cpu_row_sel  in  MAX_Z_SEGMENT  active common strobes; several may be high at once.
- lcd_blank  in  1  CPU LCD blank flag; when high, committed lines are forced dark.
- segments  out  [MAX_Z_SEGMENT-1:0] x [MAX_X_SEGMENT][MAX_Y_SEGMENT]  committed segment state.
- commit_busy  out  1  high while in the COMMIT state.

Behaviour:
- Storage:
  - acc[x][y][z]: 1 bit per segment.
  - fade[x][y][z]: $clog2(FADE_FRAMES+1) bits per segment.
  - Registered segments output.
  - State register: ACCUM or COMMIT.
  - line_idx: $clog2(MAX_X_SEGMENT) bits.
  - vblank_prev: 1 bit.
- Reset (asynchronous, reset_n low):
  - acc, fade and segments cleared to 0.
  - State = ACCUM, line_idx = 0, vblank_prev = 0, commit_busy = 0.
  - Reset asserted mid-COMMIT aborts the sweep; nothing is partially retained.
- Accumulate, in either state:
  - When cpu_seg_wr=1 and cpu_line < MAX_X_SEGMENT: acc[cpu_line][y][z] |= cpu_column_data[y] & cpu_row_sel[z].
  - cpu_line >= MAX_X_SEGMENT is ignored with no side effects.
  - Writes are ORed, so repeated writes within a frame never clear bits.
- Edge detect:
  - vblank_prev <= vblank every cycle.
  - rise = vblank & ~vblank_prev.
- ACCUM state:
  - On rise: state <= COMMIT, line_idx <= 0.
- COMMIT state, one cycle per line l = line_idx:
  - For each y,z:
    - fade_next = FADE_FRAMES if acc[l][y][z], else fade-1 if fade != 0, else 0.
    - fade[l][y][z] <= fade_next.
    - segments[l][y][z] <= (fade_next != 0) & ~lcd_blank, with lcd_blank sampled in that cycle.
  - acc[l] is cleared.
  - Then line_idx increments.
  - After l = MAX_X_SEGMENT-1: state <= ACCUM, line_idx <= 0.
  - commit_busy = 1 exactly for the MAX_X_SEGMENT COMMIT cycles (registered, state-derived).
- Simultaneous CPU write and commit of the same line l:
  - The clear applies first, then the OR.
  - The write survives in acc and counts toward the next frame; it does not affect the current commit.
- Writes to lines already swept or not yet swept in the current COMMIT:
  - Already swept: the write lands in the next frame.
  - Not yet swept: the write is included in the current commit.
- Latency:
  - Let cycle E be the cycle in which vblank is first sampled high.
  - Line l's output updates at the clock edge ending cycle E+1+l.
  - It is visible during cycle E+2+l.
- A rise during COMMIT is ignored.
  - The sweep never restarts and no second commit is queued.
- Uncommitted lines hold their previous segments values; outputs change only in COMMIT.
- Fade arithmetic saturates at 0 and never wraps.
- lcd_blank does not alter acc or fade, only the committed output.
  - Persistence therefore resumes correctly after blank is released.

Test Plan:
- Basic commit, FADE_FRAMES=2:
  - Stimulus: write line 3, data 0x0005, row_sel 0b0001, then vblank rise at cycle E.
  - Required: segments[3][0][0] = segments[3][2][0] = 1, first visible at cycle E+5.
  - Required: all other bits 0.
  - Required: commit_busy high cycles E+1..E+9.
- Persistence:
  - Stimulus: same write in frame 1 only, then 2 more vblank rises with no writes.
  - Required: the bits stay 1 after frame-2 commit and go 0 after frame-3 commit.
  - Required: with FADE_FRAMES=1 they go 0 after frame-2 commit.
- Same-line race:
  - Stimulus: write line 0, data 0x8000, row 0b0010, in the same cycle the sweep commits line 0.
  - Required: segments[0][15][1] = 0 this frame and = 1 after the next commit.
- Out-of-range and OR behaviour:
  - Stimulus: write line 12 with 0xFFFF, plus two writes to line 1 (0x00F0, then 0x000F) with row_sel 0b1111.
  - Required: no effect from line 12.
  - Required: line 1 columns 0..7 lit on all 4 rows.
- Blank:
  - Stimulus: lcd_blank=1 during a commit with lit segments.
  - Required: all committed lines read 0.
  - Stimulus: next frame with blank=0 and no writes, FADE_FRAMES=2.
  - Required: the segments reappear at 1.
- Reset mid-COMMIT:
  - Stimulus: assert reset_n=0 at sweep line 4.
  - Required: segments, acc, fade all 0 and commit_busy=0 immediately, asynchronously.
  - Required: after release, the next vblank rise performs a full 9-line sweep.
